// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, data width and baud default
// shared by the UART transmitter and receiver.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 104;

  typedef enum logic [2:0] {
    UART_IDLE   = 3'd0,
    UART_START  = 3'd1,
    UART_DATA   = 3'd2,
    UART_PARITY = 3'd3,
    UART_STOP   = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter, 0..CLKS_PER_BIT-1.
// clk, rst (async low), restart (sync clear), tick (wrap pulse).
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = !restart && (cnt == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 UART transmitter, LSB first.
// clk, rst (async low), tx_byte/transmit in; is_transmitting,
// tx, tx_done out (all registered). Define UART_TX_PARITY_EN
// to insert an even-parity bit after bit 7.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_byte,
  input  logic       transmit,
  output logic       is_transmitting,
  output logic       tx,
  output logic       tx_done
);

  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  uart_state_t          state, state_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [IW-1:0]        idx, idx_n;
  logic                 stop_idx, stop_n;
  logic                 tx_n, busy_n, done_n;
  logic                 restart, tick;
`ifdef UART_TX_PARITY_EN
  logic                 par, par_n;
`endif

  // counter is held at zero while idle so the start
  // bit gets a full period from the accepting edge
  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= UART_IDLE;
      shreg           <= '0;
      idx             <= '0;
      stop_idx        <= 1'b0;
      tx              <= 1'b1;
      is_transmitting <= 1'b0;
      tx_done         <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par             <= 1'b0;
`endif
    end else begin
      state           <= state_n;
      shreg           <= shreg_n;
      idx             <= idx_n;
      stop_idx        <= stop_n;
      tx              <= tx_n;
      is_transmitting <= busy_n;
      tx_done         <= done_n;
`ifdef UART_TX_PARITY_EN
      par             <= par_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    idx_n   = idx;
    stop_n  = stop_idx;
    tx_n    = tx;
    busy_n  = is_transmitting;
    done_n  = 1'b0;
    restart = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n   = par;
`endif
    unique case (state)
      UART_IDLE: begin
        restart = 1'b1;
        if (transmit) begin
          state_n = UART_START;
          shreg_n = tx_byte;
          idx_n   = '0;
          stop_n  = 1'b0;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
`ifdef UART_TX_PARITY_EN
          par_n   = ^tx_byte;
`endif
        end
      end
      UART_START: begin
        if (tick) begin
          state_n = UART_DATA;
          tx_n    = shreg[0];
          shreg_n = {1'b0, shreg[DATA_BITS-1:1]};
        end
      end
      UART_DATA: begin
        if (tick) begin
          idx_n = idx + IW'(1);
          if (idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_n = UART_PARITY;
            tx_n    = par;
`else
            state_n = UART_STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            tx_n    = shreg[0];
            shreg_n = {1'b0, shreg[DATA_BITS-1:1]};
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      UART_PARITY: begin
        if (tick) begin
          state_n = UART_STOP;
          tx_n    = 1'b1;
        end
      end
`endif
      UART_STOP: begin
        if (tick) begin
          if (stop_idx == 1'(STOP_BITS - 1)) begin
            state_n = UART_IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            stop_n = 1'b1;
          end
        end
      end
      default: begin
        state_n = UART_IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed frames, queued expectations
// checked by a line monitor decoding the serial output.
module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int LEN_A = PAR ? 44 : 40;
  localparam int LEN_B = PAR ? 24 : 22;

  typedef struct {
    logic [7:0] data;
    logic       par;
    int         cpb;
    int         nstop;
    int         len;
    bit         abort;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_byte_a, tx_byte_b;
  logic       transmit_a, transmit_b;
  logic       busy_a, busy_b, tx_a, tx_b, done_a, done_b;
  logic       sel;
  logic       m_tx, m_busy, m_done;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt_a = 0;
  bit mon_busy = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .tx_byte(tx_byte_a),
    .transmit(transmit_a), .is_transmitting(busy_a),
    .tx(tx_a), .tx_done(done_a)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(2), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .tx_byte(tx_byte_b),
    .transmit(transmit_b), .is_transmitting(busy_b),
    .tx(tx_b), .tx_done(done_b)
  );

  assign m_tx   = sel ? tx_b   : tx_a;
  assign m_busy = sel ? busy_b : busy_a;
  assign m_done = sel ? done_b : done_a;

  always @(negedge clk) if (done_a) done_cnt_a++;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic p,
                              input int cpb, input int ns,
                              input int len, input bit ab);
    exp_t e;
    e.data = d; e.par = p; e.cpb = cpb;
    e.nstop = ns; e.len = len; e.abort = ab;
    q.push_back(e);
  endtask

  task automatic pulse_a(input logic [7:0] b);
    tx_byte_a  = b;
    transmit_a = 1'b1;
    @(negedge clk);
    transmit_a = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (m_done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    check(name, 32'(seen), 32'd1);
  endtask

  // line monitor: find start bit, sample mid-bit, check timing
  initial begin : monitor
    exp_t e;
    bit got, busy_bad, aborted;
    logic [7:0] d;
    int k;
    forever begin
      while (q.size() == 0) @(negedge clk);
      e = q.pop_front();
      mon_busy = 1;
      got = 0;
      for (int t = 0; t < 200; t++) begin
        @(negedge clk);
        if (m_tx === 1'b0) begin
          got = 1;
          break;
        end
      end
      check("start_seen", 32'(got), 32'd1);
      if (got) begin
        d = '0; busy_bad = 0; aborted = 0;
        for (int i = 0; i <= e.len; i++) begin
          if (i > 0) @(negedge clk);
          if (rst !== 1'b1) begin
            aborted = 1;
            break;
          end
          if (i < e.len) begin
            if (m_busy !== 1'b1 || m_done !== 1'b0) busy_bad = 1;
            if (i % e.cpb == e.cpb / 2) begin
              k = i / e.cpb;
              if (k == 0)
                check("start_bit", 32'(m_tx), 32'd0);
              else if (k <= 8)
                d[k-1] = m_tx;
              else if (PAR && k == 9)
                check("parity_bit", 32'(m_tx), 32'(e.par));
              else
                check("stop_bit", 32'(m_tx), 32'd1);
            end
          end else begin
            check("done_pulse", 32'(m_done), 32'd1);
            check("busy_clear", 32'(m_busy), 32'd0);
            check("tx_idle_end", 32'(m_tx), 32'd1);
          end
        end
        check("abort_match", 32'(aborted), 32'(e.abort));
        if (!aborted) begin
          check("data", 32'(d), 32'(e.data));
          check("busy_span", 32'(busy_bad), 32'd0);
        end
      end
      mon_busy = 0;
    end
  end

  initial begin : stim
    int d0;
    bit hi;
    rst = 1'b0;
    sel = 1'b0;
    tx_byte_a = '0; transmit_a = 1'b0;
    tx_byte_b = '0; transmit_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_a",   32'(tx_a),   32'd1);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_done_a", 32'(done_a), 32'd0);
    check("rst_tx_b",   32'(tx_b),   32'd1);
    check("rst_busy_b", 32'(busy_b), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: 0x55
    expect_frame(8'h55, 1'b0, 4, 1, LEN_A, 0);
    @(negedge clk);
    pulse_a(8'h55);
    check("busy_next_cycle", 32'(busy_a), 32'd1);
    wait_done("t1_done");
    repeat (3) @(negedge clk);

    // 2: 0x80, ignored 0xFF pulse mid-frame
    d0 = done_cnt_a;
    expect_frame(8'h80, 1'b1, 4, 1, LEN_A, 0);
    @(negedge clk);
    pulse_a(8'h80);
    repeat (9) @(negedge clk);
    pulse_a(8'hFF);
    wait_done("t2_done");
    hi = 1;
    repeat (50) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0) hi = 0;
    end
    check("t2_no_queued", 32'(hi), 32'd1);
    check("t2_one_done", 32'(done_cnt_a - d0), 32'd1);

    // 3: back to back 0xA5, 0x3C
    expect_frame(8'hA5, 1'b0, 4, 1, LEN_A, 0);
    expect_frame(8'h3C, 1'b0, 4, 1, LEN_A, 0);
    @(negedge clk);
    pulse_a(8'hA5);
    wait_done("t3a_done");
    check("t3_gap_high", 32'(tx_a), 32'd1);
    pulse_a(8'h3C);
    check("t3_b2b_start", 32'(tx_a), 32'd0);
    wait_done("t3b_done");
    repeat (3) @(negedge clk);

    // 4: reset at cycle 17 of a 0x00 frame
    expect_frame(8'h00, 1'b0, 4, 1, LEN_A, 1);
    @(negedge clk);
    pulse_a(8'h00);
    repeat (16) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("t4_async_tx",   32'(tx_a),   32'd1);
    check("t4_async_busy", 32'(busy_a), 32'd0);
    check("t4_async_done", 32'(done_a), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    hi = 1;
    repeat (30) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0) hi = 0;
    end
    check("t4_stays_idle", 32'(hi), 32'd1);
    expect_frame(8'h0F, 1'b0, 4, 1, LEN_A, 0);
    @(negedge clk);
    pulse_a(8'h0F);
    wait_done("t4_done");
    repeat (3) @(negedge clk);

`ifdef UART_TX_PARITY_EN
    // 5: parity frames
    expect_frame(8'h07, 1'b1, 4, 1, 44, 0);
    @(negedge clk);
    pulse_a(8'h07);
    wait_done("t5a_done");
    repeat (2) @(negedge clk);
    expect_frame(8'h03, 1'b0, 4, 1, 44, 0);
    @(negedge clk);
    pulse_a(8'h03);
    wait_done("t5b_done");
    repeat (3) @(negedge clk);
`endif

    // 6: two stop bits, 2 clk per bit
    sel = 1'b1;
    expect_frame(8'hC3, 1'b0, 2, 2, LEN_B, 0);
    @(negedge clk);
    tx_byte_b  = 8'hC3;
    transmit_b = 1'b1;
    @(negedge clk);
    transmit_b = 1'b0;
    wait_done("t6_done");
    repeat (3) @(negedge clk);

    hi = 0;
    for (int t = 0; t < 300; t++) begin
      if (q.size() == 0 && !mon_busy) begin
        hi = 1;
        break;
      end
      @(negedge clk);
    end
    check("drain", 32'(hi), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
